// File: rtl/reg_dump_unit.sv
// reg_dump_unit: walks every register-file entry through a combinational read
// port and streams (index, value) pairs out over a valid/ready handshake.
//
// Ports:
//   clock, reset        - system clock; asynchronous active-high reset
//   start, except       - dump triggers, honoured only while idle
//   rf_addr / rf_data   - register-file read port (data valid same cycle)
//   out_valid/out_ready - entry handshake; out_index/out_data hold the entry
//   busy, done          - dump in progress; one-cycle completion pulse
//
// Optional build macro DUMP_SKIP_ZERO_EN: registers reading zero are skipped.

module reg_dump_unit #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  except,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH-1:0]   idx_nxt;
  logic                    capture;   // latch rf_data into the output entry
  logic                    accept;    // entry taken by the sink this cycle

  assign accept = (state == SEND) && out_ready;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start || except) begin
          state_nxt = READ;
          idx_nxt   = '0;
        end
      end
      READ: begin
`ifdef DUMP_SKIP_ZERO_EN
        if (rf_data == '0) begin
          // Zero register: spend one cycle and move on without an entry.
          if (idx == LAST_IDX) begin
            state_nxt = FIN;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
`else
        capture   = 1'b1;
        state_nxt = SEND;
`endif
      end
      SEND: begin
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = FIN;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = READ;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and index registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Output entry register: captured once in READ, then frozen through SEND so
  // later register-file writes cannot disturb an offered entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_index <= idx;
      out_data  <= rf_data;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  // Address held on idx in both READ and SEND so the rf output is consistent.
  assign rf_addr = idx;
  assign busy    = (state == READ) || (state == SEND);
  assign done    = (state == FIN);

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed testbench for reg_dump_unit with a behavioural register file,
// an entry monitor and a reference list of expected dump entries.

module tb_reg_dump_unit;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] index;
    logic [DW-1:0] data;
  } entry_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          except = 1'b0;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_index;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] rf [NR];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  entry_t got_q[$];
  entry_t exp_q[$];

  reg_dump_unit #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .except    (except),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  assign rf_data = rf[rf_addr];

  always @(posedge clock) cyc++;

  // Inputs only change 1ns after posedge, so negedge sees the values that the
  // next posedge will act on.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        entry_t e;
        e.index = out_index;
        e.data  = out_data;
        got_q.push_back(e);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: entries the current rf contents should produce.
  task automatic build_expected();
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      entry_t e;
      e.index = AW'(i);
      e.data  = rf[i];
`ifdef DUMP_SKIP_ZERO_EN
      if (rf[i] != '0) exp_q.push_back(e);
`else
      exp_q.push_back(e);
`endif
    end
  endtask

  task automatic compare_dump(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_idx%0d", tag, i), got_q[i].index, exp_q[i].index);
      check($sformatf("%s_dat%0d", tag, i), got_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    if (done_cnt == d0) check({tag, "_done_timeout"}, 0, 1);
  endtask

  // Advance until the unit is in READ for register i (out_valid low, busy high).
  task automatic wait_read(input string tag, input int i);
    int k;
    k = 0;
    while (!(busy && !out_valid && rf_addr == AW'(i)) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check({tag, "_read_timeout"}, 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int trig;
    int n7;
    int nq;
    int nd;

    for (int i = 0; i < NR; i++) rf[i] = DW'(i * 3);

    // ---- reset values
    repeat (2) tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", rf_addr, 0);
    check("rst_index", out_index, 0);
    check("rst_data", out_data, 0);
    reset = 1'b0;
    tick();

    // ---- full dump, rf[i]=i*3, ready high
    got_q.delete();
    done_cnt = 0;
    start = 1'b1;
    tick();
    trig = cyc;
    start = 1'b0;
    check("t1_busy_read", busy, 1);
    check("t1_valid_read", out_valid, 0);
    check("t1_addr_read", rf_addr, 0);
    tick();
    check("t1_valid_send", out_valid, 1);
    check("t1_index_send", out_index, 0);
    wait_done("t1", 200);
    build_expected();
    compare_dump("t1");
    // trigger edge counted as cycle 1
    check("t1_done_cycle", done_cyc - trig + 1, 65);
    tick();
    check("t1_done_once", done_cnt, 1);
    check("t1_busy_after", busy, 0);
    check("t1_done_low", done, 0);

    // ---- except trigger
    rf[5] = 32'hDEADBEEF;
    got_q.delete();
    done_cnt = 0;
    except = 1'b1;
    tick();
    except = 1'b0;
    check("t2_busy", busy, 1);
    wait_done("t2", 200);
    build_expected();
    compare_dump("t2");
    check("t2_e5_idx", (got_q.size() > 5) ? got_q[5].index : 5'h1f, 5);
    check("t2_e5_dat", (got_q.size() > 5) ? got_q[5].data : 32'h0, 32'hDEADBEEF);
    rf[5] = 32'd15;

    // ---- stall on entry 7 with rf changing underneath
    rf[7] = 32'h1234;
    got_q.delete();
    done_cnt = 0;
    pulse_start();
    wait_read("t3", 7);
    out_ready = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t3_valid_c%0d", k), out_valid, 1);
      check($sformatf("t3_index_c%0d", k), out_index, 7);
      check($sformatf("t3_data_c%0d", k), out_data, 32'h1234);
      if (k == 0) rf[7] = 32'hFFFF;
      tick();
    end
    out_ready = 1'b1;
    wait_done("t3", 200);
    n7 = 0;
    foreach (got_q[i]) if (got_q[i].index == 5'd7) n7++;
    check("t3_e7_count", n7, 1);
    check("t3_total", got_q.size(), 32);
    check("t3_e7_dat", (got_q.size() > 7) ? got_q[7].data : 32'h0, 32'h1234);
    rf[7] = 32'd21;

    // ---- start during dump is ignored
    got_q.delete();
    done_cnt = 0;
    pulse_start();
    wait_read("t4", 12);
    tick();
    pulse_start();
    wait_done("t4", 200);
    repeat (6) tick();
    build_expected();
    compare_dump("t4");
    check("t4_done_once", done_cnt, 1);
    check("t4_busy_after", busy, 0);

    // ---- async reset mid-SEND at entry 20
    got_q.delete();
    done_cnt = 0;
    pulse_start();
    wait_read("t5", 20);
    out_ready = 1'b0;
    tick();
    check("t5_valid_pre", out_valid, 1);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("t5_valid_rst", out_valid, 0);
    check("t5_busy_rst", busy, 0);
    check("t5_addr_rst", rf_addr, 0);
    nq = got_q.size();
    nd = done_cnt;
    @(posedge clock);
    #3;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    check("t5_no_entries", got_q.size(), nq);
    check("t5_no_done", done_cnt, nd);
    check("t5_idle_busy", busy, 0);
    got_q.delete();
    done_cnt = 0;
    pulse_start();
    wait_done("t5b", 200);
    build_expected();
    compare_dump("t5b");

    // ---- zero registers at both ends
    for (int i = 0; i < NR; i++) rf[i] = DW'(i + 1);
    rf[0]  = '0;
    rf[31] = '0;
    got_q.delete();
    done_cnt = 0;
    pulse_start();
    wait_done("t6", 200);
    tick();
    build_expected();
    compare_dump("t6");
    check("t6_done_once", done_cnt, 1);
`ifdef DUMP_SKIP_ZERO_EN
    check("t6_count_fixed", got_q.size(), 30);
    check("t6_first_idx", (got_q.size() > 0) ? got_q[0].index : 5'h1f, 1);
`else
    check("t6_count_fixed", got_q.size(), 32);
    check("t6_first_dat", (got_q.size() > 0) ? got_q[0].data : 32'hFFFF_FFFF, 0);
    check("t6_last_dat", (got_q.size() > 31) ? got_q[31].data : 32'hFFFF_FFFF, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
- Hardware counterpart of the bench's register dump: reads every register-file entry through a read port and streams each value out over a valid/ready handshake.
- Sits beside arith_machine.
- Triggered by a software "done" strobe or by the machine's except output.
- Drives its own rf read address, so the machine must be halted while busy is high.

Parameters:
NUM_REGS, 32, number of register-file entries dumped (2..2^ADDR_WIDTH)
ADDR_WIDTH, 5, width of register index / rf read address
DATA_WIDTH, 32, register data width

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high; forces IDLE immediately
start  input  1  dump request, sampled in IDLE only
except  input  1  machine exception; same effect as start
rf_addr  output  ADDR_WIDTH  register-file read address (combinational-read rf)
rf_data  input  DATA_WIDTH  register-file read data for rf_addr, same cycle
out_valid  output  1  out_index/out_data hold a valid entry
out_ready  input  1  sink accepts entry when out_valid & out_ready at posedge
out_index  output  ADDR_WIDTH  register number of current entry
out_data  output  DATA_WIDTH  register value of current entry
busy  output  1  high in READ and SEND
done  output  1  one-cycle pulse after last entry is accepted

Behaviour:
- Reset values: rf_addr=0, out_valid=0, out_index=0, out_data=0, busy=0, done=0, idx=0, state=IDLE.
- Reset mid-dump aborts the dump; no further entries are produced.
- States: IDLE, READ, SEND, FIN.
- IDLE:
  - start|except at posedge -> READ, idx=0.
  - Triggers in any other state are ignored; they are not queued.
- READ (busy=1, rf_addr=idx):
  - At posedge, out_data<=rf_data, out_index<=idx, out_valid<=1 -> SEND.
- SEND (busy=1, out_valid=1):
  - out_index and out_data are stable until handshake.
  - rf_addr holds idx.
  - On out_valid & out_ready: out_valid<=0.
    - If idx==NUM_REGS-1 -> FIN.
    - Otherwise idx<=idx+1 -> READ.
  - out_ready low stalls indefinitely with no timeout.
- FIN:
  - done=1 for exactly one cycle, busy=0 -> IDLE.
  - start held high through FIN starts a new dump on the following IDLE cycle.
- Latency: trigger edge -> out_valid high after 2 posedges (IDLE->READ->SEND).
- Throughput: one entry per 2 cycles with out_ready tied high.
- Full dump of 32 regs with ready=1: done pulses 65 cycles after trigger edge.
- idx increments with no wrap: it stops at NUM_REGS-1, and idx never reaches NUM_REGS.
- out_data is captured registered data: later rf changes do not alter an entry once in SEND.
- The same rf_addr is held in READ and SEND, so a combinational rf returns consistent data.

Optional Feature:
- Macro: DUMP_SKIP_ZERO_EN.
- Defined:
  - In READ, if rf_data==0, no entry is produced.
  - If idx<NUM_REGS-1: idx<=idx+1, stay in READ (one cycle per skipped register).
  - If idx==NUM_REGS-1: -> FIN.
  - done still pulses once even if all registers are zero and no entry was emitted.
- Undefined: every register is emitted, including zeros and r0.

Test Plan:
- Reset then start pulse, rf[i]=i*3, out_ready=1 -> 32 entries, index 0..31, data 0,3,...,93, in order; done pulses once at cycle 65; busy low afterwards.
- except=1 (start=0), rf[5]=0xDEADBEEF, out_ready=1 -> entry index 5 data 0xDEADBEEF; triggers identically to start.
- out_ready held low 10 cycles during entry 7 (rf[7]=0x1234) -> out_valid, out_index=7, out_data=0x1234 stable for all 10 cycles, even with rf[7] changed to 0xFFFF; exactly one entry 7 accepted.
- start pulsed again at entry 12 -> ignored; exactly 32 entries and one done pulse.
- reset asserted asynchronously mid-SEND at entry 20 (between clock edges) -> out_valid/busy drop immediately; with out_ready=1 held after reset release, no entries are produced; the next start dumps from index 0.
- DUMP_SKIP_ZERO_EN defined, only rf[0]=0 and rf[31]=0 -> 30 entries, indices 1..30; done pulses once. Not defined, same rf -> 32 entries including two zero values.
